idex_stage_reg: RTL and testbench
=================================

Name: idex_stage_reg

Overview:
- Parametrised decode-to-execute pipeline stage register for the RISC-V core.
- Carries a packed control bundle plus operands from decode to execute with a valid/ready handshake and a 2-entry skid buffer.
- Adds flush, load-use hazard stall with bubble insertion, and a saturating stall counter.
- Sits between the decode logic (control, immGen, RegFile read) and the execute stage.

Parameters:
- XLEN, 32, datapath width of r1/r2/imm/pc.
- RA_W, 5, register address width.
- CTRL_W, 16, control bundle width; bit map: [15] RegWrite, [14] MemWrite, [13] MemtoReg, [12] PCBranch, [11] JALRctrl, [10:9] SrcASel, [8:7] SrcBSel, [6:3] ALUop, [2:0] strCtrl.
- RST_CTRL, 16'h0B80, NOP/reset bundle: JALRctrl=1, SrcASel=01, SrcBSel=11, all other bits 0.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_d  in  1  decode entry valid.
- ready_d  out  1  stage can accept.
- ctrl_d  in  CTRL_W  decoded control bundle.
- r1_d, r2_d, imm_d, pc_d  in  XLEN  operands, immediate, PC.
- rd_d, rs1_d, rs2_d  in  RA_W  register indices.
- use_rs1_d, use_rs2_d  in  1  instruction reads rs1 / rs2.
- valid_e  out  1  execute entry valid.
- ready_e  in  1  execute accepts.
- ctrl_e  out  CTRL_W  control bundle; RST_CTRL whenever valid_e=0.
- r1_e, r2_e, imm_e, pc_e  out  XLEN  registered data.
- rd_e, rs1_e, rs2_e  out  RA_W  registered indices.
- flush  in  1  kill all held entries (taken branch/jump in EX).
- wb_we  in  1  writeback enable.
- wb_rd  in  RA_W  writeback index.
- wb_data  in  XLEN  writeback value.
- stall_cnt  out  CNT_W  count of hazard-stall cycles.

Behaviour:
- push = valid_d & ready_d; pop = valid_e & ready_e.
- FSM states: EMPTY, ONE (main entry valid), FULL (main + skid).
  - EMPTY: push -> ONE, main <= in.
  - ONE: push & pop -> ONE, main <= in; push & !pop -> FULL, skid <= in; !push & pop -> EMPTY.
  - FULL: pop -> ONE, main <= skid; no push is possible.
- Latency: 1 cycle from push to valid_e when the stage is EMPTY, or when in ONE with a simultaneous pop.
- valid_e = (state != EMPTY). Outputs come from main only.
- hazard = (state==ONE) & main.MemtoReg & main.rd!=0 & ((use_rs1_d & rs1_d==main.rd) | (use_rs2_d & rs2_d==main.rd)).
- ready_d = !rst & (state != FULL) & !hazard. Combinational on the decode inputs.
- Hazard releases once the load pops, giving exactly one bubble; the bubble is longer while ready_e=0.
- flush has priority over everything: next state EMPTY, any same-cycle push is discarded, skid is cleared.
- stall_cnt increments on each cycle with valid_d & hazard & !flush. It saturates at all-ones. It is not cleared by flush.
- Data outputs hold their last value when invalid. ctrl_e is forced to RST_CTRL whenever valid_e=0.
- Reset values: state EMPTY, valid_e=0, ready_d=0 during rst, ctrl_e=RST_CTRL, all data/index outputs 0, stall_cnt=0.
- rst asserted mid-transfer drops all entries.
- rd=0 never triggers a hazard.

Optional Feature:
- Macro: IDEX_WB_BYPASS_EN.
- Defined: on push, if wb_we & wb_rd!=0 & wb_rd==rs1_d, r1 is captured from wb_data; same rule for rs2/r2.
  - Fixes RegFile read-before-write in the same cycle.
  - Applies equally when writing main or skid.
- Undefined: r1_d/r2_d are captured unchanged; wb_* ports exist but are unused.

Decomposition:
- Package idex_pkg holds:
  - control bit-index localparams (CTRL_REGWRITE=15 … CTRL_STR_LSB=0);
  - RST_CTRL default;
  - FSM state enum (EMPTY/ONE/FULL);
  - a payload struct (ctrl, r1, r2, imm, pc, rd, rs1, rs2).
- Sub-module idex_hazard_unit: combinational load-use compare, producing hazard. Kept separate for reuse by a future forwarding unit.

Test Plan:
- Reset: hold rst 2 cycles with valid_d=1 -> valid_e=0, ctrl_e=16'h0B80, ready_d=0, stall_cnt=0.
- Pass-through: ready_e=1, push pc_d=0x100 then 0x104 -> valid_e at next edge, pc_e=0x100 then 0x104 on consecutive cycles, no gaps.
- Backpressure:
  - ready_e=0, push 0x200 and 0x204 -> state FULL, ready_d=0, pc_e=0x200.
  - Raise ready_e -> 0x200, then 0x204 popped in order, no loss.
- Load-use: main=lw x5 (MemtoReg=1, rd=5); decode add with rs1=5, use_rs1_d=1 -> ready_d=0 one cycle, one bubble (valid_e=0, ctrl_e=RST_CTRL), stall_cnt=1, then add issues.
- Flush: state FULL, flush=1 with valid_d=1 -> next cycle state EMPTY, valid_e=0, pushed entry absent.
- Bypass (with IDEX_WB_BYPASS_EN): wb_we=1, wb_rd=3, wb_data=0xDEAD; push with rs1_d=3, r1_d=0 -> r1_e=0xDEAD. Without the macro -> r1_e=0.

Source files
------------

// File: rtl/idex_pkg.sv
// ============================================================================
// Module      : idex_pkg
// Description : Shared definitions for the decode-to-execute stage register:
//               control-bundle bit map, NOP/reset bundle, occupancy FSM
//               states and the default-width payload record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package idex_pkg;

  // Default datapath geometry of the core
  localparam int IDEX_XLEN   = 32;
  localparam int IDEX_RA_W   = 5;
  localparam int IDEX_CTRL_W = 16;

  // Control bundle bit map
  localparam int CTRL_REGWRITE  = 15;
  localparam int CTRL_MEMWRITE  = 14;
  localparam int CTRL_MEMTOREG  = 13;
  localparam int CTRL_PCBRANCH  = 12;
  localparam int CTRL_JALR      = 11;
  localparam int CTRL_SRCA_MSB  = 10;
  localparam int CTRL_SRCA_LSB  = 9;
  localparam int CTRL_SRCB_MSB  = 8;
  localparam int CTRL_SRCB_LSB  = 7;
  localparam int CTRL_ALUOP_MSB = 6;
  localparam int CTRL_ALUOP_LSB = 3;
  localparam int CTRL_STR_MSB   = 2;
  localparam int CTRL_STR_LSB   = 0;

  // NOP bundle: JALRctrl=1, SrcASel=01, SrcBSel=11, everything else 0
  localparam logic [IDEX_CTRL_W-1:0] RST_CTRL_DEFAULT = 16'h0B80;

  // Stage occupancy: nothing held, main entry only, main plus skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  // One decoded instruction as carried into execute (default widths)
  typedef struct packed {
    logic [IDEX_CTRL_W-1:0] ctrl;
    logic [IDEX_XLEN-1:0]   r1;
    logic [IDEX_XLEN-1:0]   r2;
    logic [IDEX_XLEN-1:0]   imm;
    logic [IDEX_XLEN-1:0]   pc;
    logic [IDEX_RA_W-1:0]   rd;
    logic [IDEX_RA_W-1:0]   rs1;
    logic [IDEX_RA_W-1:0]   rs2;
  } idex_payload_t;

endpackage : idex_pkg

`default_nettype wire

// File: rtl/idex_hazard_unit.sv
// ============================================================================
// Module      : idex_hazard_unit
// Description : Combinational load-use detector. Flags a decode instruction
//               that reads the destination of a load sitting alone in the
//               stage register. x0 never creates a dependency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_hazard_unit
  import idex_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  stage_state_t    state,
  input  logic            main_is_load,
  input  logic [RA_W-1:0] main_rd,
  input  logic [RA_W-1:0] rs1_d,
  input  logic [RA_W-1:0] rs2_d,
  input  logic            use_rs1_d,
  input  logic            use_rs2_d,
  output logic            hazard
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1_d && (rs1_d == main_rd);
  assign rs2_hit = use_rs2_d && (rs2_d == main_rd);

  // Only a lone load can stall: in FULL the stage refuses input anyway
  assign hazard = (state == ONE) && main_is_load && (main_rd != '0) &&
                  (rs1_hit || rs2_hit);

endmodule : idex_hazard_unit

`default_nettype wire

// File: rtl/idex_stage_reg.sv
// ============================================================================
// Module      : idex_stage_reg
// Description : Decode-to-execute pipeline register with valid/ready
//               handshake, 2-entry skid buffer, flush, load-use stall with
//               bubble insertion and a saturating stall counter.
//               Optional macro IDEX_WB_BYPASS_EN: capture the writeback value
//               instead of the RegFile read when decode reads the register
//               being written back in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idex_stage_reg
  import idex_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                RA_W     = 5,
  parameter int                CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] RST_CTRL = RST_CTRL_DEFAULT,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  // decode side
  input  logic              valid_d,
  output logic              ready_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [XLEN-1:0]   r1_d,
  input  logic [XLEN-1:0]   r2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [RA_W-1:0]   rd_d,
  input  logic [RA_W-1:0]   rs1_d,
  input  logic [RA_W-1:0]   rs2_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  // execute side
  output logic              valid_e,
  input  logic              ready_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   r1_e,
  output logic [XLEN-1:0]   r2_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [RA_W-1:0]   rd_e,
  output logic [RA_W-1:0]   rs1_e,
  output logic [RA_W-1:0]   rs2_e,
  // control
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Payload record sized by this instance's parameters
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   r1;
    logic [XLEN-1:0]   r2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
  } payload_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_state_t state;
  payload_t     main;
  payload_t     skid;
  payload_t     in_pl;
  logic         hazard;
  logic         push;
  logic         pop;

  idex_hazard_unit #(
    .RA_W (RA_W)
  ) u_hazard (
    .state        (state),
    .main_is_load (main.ctrl[CTRL_MEMTOREG]),
    .main_rd      (main.rd),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .use_rs1_d    (use_rs1_d),
    .use_rs2_d    (use_rs2_d),
    .hazard       (hazard)
  );

  assign valid_e = (state != EMPTY);
  assign ready_d = !rst && (state != FULL) && !hazard;
  assign push    = valid_d && ready_d;
  assign pop     = valid_e && ready_e;

  // Assemble the incoming entry, optionally overriding stale RegFile reads
  always_comb begin
    in_pl.ctrl = ctrl_d;
    in_pl.r1   = r1_d;
    in_pl.r2   = r2_d;
    in_pl.imm  = imm_d;
    in_pl.pc   = pc_d;
    in_pl.rd   = rd_d;
    in_pl.rs1  = rs1_d;
    in_pl.rs2  = rs2_d;
`ifdef IDEX_WB_BYPASS_EN
    if (wb_we && (wb_rd != '0) && (wb_rd == rs1_d)) begin
      in_pl.r1 = wb_data;
    end
    if (wb_we && (wb_rd != '0) && (wb_rd == rs2_d)) begin
      in_pl.r2 = wb_data;
    end
`endif
  end

`ifndef IDEX_WB_BYPASS_EN
  // Writeback ports are kept for a uniform interface but have no effect here
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

  // Occupancy FSM with main/skid storage; flush overrides any transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main      <= '0;
      main.ctrl <= RST_CTRL;
      skid      <= '0;
    end else if (flush) begin
      state <= EMPTY;
      skid  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main  <= in_pl;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main <= in_pl;
          end else if (push) begin
            skid  <= in_pl;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Count cycles in which decode is held back by a load-use dependency
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (valid_d && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Execute sees a NOP bundle whenever nothing valid is presented
  assign ctrl_e = valid_e ? main.ctrl : RST_CTRL;
  assign r1_e   = main.r1;
  assign r2_e   = main.r2;
  assign imm_e  = main.imm;
  assign pc_e   = main.pc;
  assign rd_e   = main.rd;
  assign rs1_e  = main.rs1;
  assign rs2_e  = main.rs2;

endmodule : idex_stage_reg

`default_nettype wire

// File: tb/tb_idex_stage_reg.sv
// ============================================================================
// Module      : tb_idex_stage_reg
// Description : Self-checking bench for idex_stage_reg. A queue-based model
//               of the stage is compared against the DUT every cycle, and
//               directed scenarios pin hand-computed values.
//               Build with IDEX_WB_BYPASS_EN to exercise the bypass variant.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_idex_stage_reg;
  import idex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d, ready_d, valid_e, ready_e, flush;
  logic [15:0] ctrl_d, ctrl_e, stall_cnt;
  logic [31:0] r1_d, r2_d, imm_d, pc_d, r1_e, r2_e, imm_e, pc_e, wb_data;
  logic [4:0]  rd_d, rs1_d, rs2_d, rd_e, rs1_e, rs2_e, wb_rd;
  logic        use_rs1_d, use_rs2_d, wb_we;

  always #5 clk = ~clk;

  idex_stage_reg dut (
    .clk(clk), .rst(rst),
    .valid_d(valid_d), .ready_d(ready_d), .ctrl_d(ctrl_d),
    .r1_d(r1_d), .r2_d(r2_d), .imm_d(imm_d), .pc_d(pc_d),
    .rd_d(rd_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
    .valid_e(valid_e), .ready_e(ready_e), .ctrl_e(ctrl_e),
    .r1_e(r1_e), .r2_e(r2_e), .imm_e(imm_e), .pc_e(pc_e),
    .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an ordered queue of at most 2 ----------------
  idex_payload_t q[$];
  idex_payload_t held;
  int unsigned   m_cnt;
  bit            m_ok = 1'b0;
  bit            m_hz, m_rdy, m_push, m_pop;

  function automatic idex_payload_t in_payload();
    idex_payload_t p;
    p.ctrl = ctrl_d; p.r1 = r1_d; p.r2 = r2_d; p.imm = imm_d; p.pc = pc_d;
    p.rd = rd_d; p.rs1 = rs1_d; p.rs2 = rs2_d;
`ifdef IDEX_WB_BYPASS_EN
    if (wb_we && wb_rd != 0 && wb_rd == rs1_d) p.r1 = wb_data;
    if (wb_we && wb_rd != 0 && wb_rd == rs2_d) p.r2 = wb_data;
`endif
    return p;
  endfunction

  // A single buffered load whose nonzero destination decode wants to read
  function automatic bit model_hazard();
    if (q.size() != 1) return 1'b0;
    if (!q[0].ctrl[13] || q[0].rd == 0) return 1'b0;
    return (use_rs1_d && rs1_d == q[0].rd) || (use_rs2_d && rs2_d == q[0].rd);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      held  = '0;
      m_cnt = 0;
      m_ok  = 1'b1;
    end else begin
      m_hz   = model_hazard();
      m_rdy  = (q.size() < 2) && !m_hz;
      m_push = valid_d && m_rdy;
      m_pop  = (q.size() > 0) && ready_e;
      if (valid_d && m_hz && !flush && m_cnt < 65535) m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(in_payload());
      end
      if (q.size() > 0) held = q[0];
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (m_ok) begin
      chk("valid_e", valid_e, q.size() > 0);
      chk("ready_d", ready_d, !rst && q.size() < 2 && !model_hazard());
      chk("ctrl_e", ctrl_e, (q.size() > 0) ? held.ctrl : 16'h0B80);
      chk("pc_e", pc_e, held.pc);
      chk("r1_e", r1_e, held.r1);
      chk("r2_e", r2_e, held.r2);
      chk("imm_e", imm_e, held.imm);
      chk("rd_e", rd_e, held.rd);
      chk("rs1_e", rs1_e, held.rs1);
      chk("rs2_e", rs2_e, held.rs2);
      chk("stall_cnt", stall_cnt, m_cnt[15:0]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2);
    valid_d = v; pc_d = pc; ctrl_d = ctrl; rd_d = rd; rs1_d = rs1; rs2_d = rs2;
    use_rs1_d = u1; use_rs2_d = u2;
    r1_d = pc ^ 32'hA5A5_0000; r2_d = pc + 32'h10; imm_d = ~pc;
  endtask

  initial begin
    rst = 1'b1; ready_e = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drv(1'b1, 32'h0, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);

    // Reset held two cycles with valid_d high
    tick(); tick(); #1;
    chk("rst_valid_e", valid_e, 0);
    chk("rst_ctrl_e", ctrl_e, 16'h0B80);
    chk("rst_ready_d", ready_d, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_pc_e", pc_e, 0);

    // Pass-through
    rst = 1'b0; ready_e = 1'b1;
    drv(1'b1, 32'h100, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    tick(); drv(1'b1, 32'h104, 16'h8001, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1); #1;
    chk("pt_valid_1", valid_e, 1);
    chk("pt_pc_1", pc_e, 32'h100);
    tick(); drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    chk("pt_valid_2", valid_e, 1);
    chk("pt_pc_2", pc_e, 32'h104);
    chk("pt_ctrl_2", ctrl_e, 16'h8001);
    tick(); #1;
    chk("pt_drain_valid", valid_e, 0);
    chk("pt_drain_ctrl", ctrl_e, 16'h0B80);
    chk("pt_hold_pc", pc_e, 32'h104);

    // Backpressure fills main and skid
    ready_e = 1'b0;
    drv(1'b1, 32'h200, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick(); drv(1'b1, 32'h204, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); #1;
    chk("bp_pc_main", pc_e, 32'h200);
    tick(); drv(1'b1, 32'h208, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); #1;
    chk("bp_full_ready", ready_d, 0);
    chk("bp_full_pc", pc_e, 32'h200);
    tick(); drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); ready_e = 1'b1; #1;
    chk("bp_pop1_pc", pc_e, 32'h200);
    tick(); #1;
    chk("bp_pop2_pc", pc_e, 32'h204);
    chk("bp_pop2_valid", valid_e, 1);
    tick(); #1;
    chk("bp_empty", valid_e, 0);

    // Load-use: lw x5 then add reading x5
    ready_e = 1'b0;
    drv(1'b1, 32'h300, 16'hA000, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
    tick(); drv(1'b1, 32'h304, 16'h8000, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0); ready_e = 1'b1; #1;
    chk("lu_stall_ready", ready_d, 0);
    chk("lu_load_pc", pc_e, 32'h300);
    tick(); #1;
    chk("lu_bubble_valid", valid_e, 0);
    chk("lu_bubble_ctrl", ctrl_e, 16'h0B80);
    chk("lu_release", ready_d, 1);
    chk("lu_cnt", stall_cnt, 1);
    tick(); drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    chk("lu_add_pc", pc_e, 32'h304);
    chk("lu_add_ctrl", ctrl_e, 16'h8000);
    chk("lu_add_rd", rd_e, 6);
    tick();

    // Load to x0 never stalls; then flush while FULL
    ready_e = 1'b0;
    drv(1'b1, 32'h400, 16'hA000, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
    tick(); drv(1'b1, 32'h404, 16'h8000, 5'd3, 5'd0, 5'd0, 1'b1, 1'b1); #1;
    chk("x0_no_hazard", ready_d, 1);
    tick(); drv(1'b1, 32'h408, 16'h8000, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0); flush = 1'b1; #1;
    chk("fl_full_ready", ready_d, 0);
    tick(); flush = 1'b0; drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    chk("fl_valid", valid_e, 0);
    chk("fl_ctrl", ctrl_e, 16'h0B80);
    tick(); #1;
    chk("fl_absent", valid_e, 0);

    // Flush from ONE discards a same-cycle push
    drv(1'b1, 32'h500, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick(); drv(1'b1, 32'h504, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); flush = 1'b1; #1;
    chk("fl1_ready", ready_d, 1);
    tick(); flush = 1'b0; drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    chk("fl1_valid", valid_e, 0);
    chk("fl1_hold_pc", pc_e, 32'h500);
    tick(); #1;
    chk("fl1_absent", valid_e, 0);

    // Extended stall under backpressure via rs2; flush does not count or clear
    drv(1'b1, 32'h600, 16'hA000, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
    tick(); drv(1'b1, 32'h604, 16'h8000, 5'd8, 5'd1, 5'd7, 1'b0, 1'b1);
    tick(); tick(); tick(); #1;
    chk("st_cnt3", stall_cnt, 4);
    chk("st_ready", ready_d, 0);
    flush = 1'b1;
    tick(); flush = 1'b0; drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); #1;
    chk("st_cnt_flush", stall_cnt, 4);
    chk("st_valid_flush", valid_e, 0);

    // Writeback bypass on rs1 and rs2
    ready_e = 1'b1;
    drv(1'b1, 32'h700, 16'h8000, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1);
    r1_d = 32'h0; r2_d = 32'h55;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
    tick(); drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); wb_we = 1'b0; #1;
`ifdef IDEX_WB_BYPASS_EN
    chk("byp_r1", r1_e, 32'hDEAD);
    chk("byp_r2", r2_e, 32'hDEAD);
`else
    chk("byp_r1", r1_e, 32'h0);
    chk("byp_r2", r2_e, 32'h55);
`endif
    tick();

    // Reset in the middle of a full stage
    ready_e = 1'b0;
    drv(1'b1, 32'h800, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick(); drv(1'b1, 32'h804, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    tick(); rst = 1'b1; drv(1'b1, 32'h808, 16'h8000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); #1;
    chk("mr_ready", ready_d, 0);
    tick(); #1;
    chk("mr_valid", valid_e, 0);
    chk("mr_ctrl", ctrl_e, 16'h0B80);
    chk("mr_pc", pc_e, 0);
    rst = 1'b0; drv(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(); tick(); #1;
    chk("mr_after_valid", valid_e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_idex_stage_reg

`default_nettype wire
